// File: rtl/chunked_adder_seq_if.sv
// Operand/result handshake bundle for chunked_adder_seq.
// Handshake: a transfer happens on a rising edge where valid && ready are both high; the producer holds its payload until then.
interface chunked_adder_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_adder_seq.sv
// Sequential adder/subtractor: CHUNK bits per cycle, LSB chunk first, carry kept in a register.
// Optional macro CHUNKED_ADDER_SAT_EN saturates sum to the signed extreme on overflow.
module chunked_adder_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  chunked_adder_seq_if.slave bus,
  output logic [1:0]         o_dbg_state
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_next;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic             r_carry, r_cout, r_ovf;

  logic             w_in_ready, w_out_valid, w_last;
  logic [CHUNK:0]   w_chunk;
  logic [WIDTH-1:0] w_acc_next, w_sum_final;
  logic             w_msb_cin, w_ovf;
  int               w_base;

  assign w_base  = int'(r_k) * CHUNK;
  assign w_chunk = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_b[w_base +: CHUNK]}
                 + {{CHUNK{1'b0}}, r_carry};
  assign w_last  = (r_k == KW'(NCHUNK - 1));

  // Carry into the MSB recovered from the MSB sum bit; only meaningful on the last chunk.
  assign w_msb_cin = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_chunk[CHUNK-1];
  assign w_ovf     = w_msb_cin ^ w_chunk[CHUNK];

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[w_base +: CHUNK] = w_chunk[CHUNK-1:0];
  end

`ifdef CHUNKED_ADDER_SAT_EN
  always_comb begin
    w_sum_final = w_acc_next;
    if (w_ovf) begin
      w_sum_final = w_acc_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                        : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign w_sum_final = w_acc_next;
`endif

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_k     <= '0;
            r_acc   <= '0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_chunk[CHUNK];
          r_k     <= w_last ? '0 : r_k + KW'(1);
          // Results only change here, so they hold through DONE and beyond.
          if (w_last) begin
            r_sum  <= w_sum_final;
            r_cout <= w_chunk[CHUNK];
            r_ovf  <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_chunked_adder_seq.sv
// Self-checking bench for chunked_adder_seq (WIDTH=16, CHUNK=4): directed corners, backpressure, reset, random ops.
module tb_chunked_adder_seq;
  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int SMAX   = (1 << (WIDTH - 1)) - 1;
  localparam int SMIN   = -(1 << (WIDTH - 1));
  localparam int UMAX   = (1 << WIDTH) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  chunked_adder_seq_if #(.WIDTH(WIDTH)) bus ();

  chunked_adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH+1:0] exp_q[$];  // {ovf, cout, sum}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed and unsigned integer arithmetic straight from the operation's definition.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
    int sa, sb, ua, ub, r;
    logic ovf, cout;
    logic [WIDTH-1:0] s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = a;
    ub = b;
    r  = sub ? (sa - sb) : (sa + sb + int'(cin));
    ovf  = (r > SMAX) || (r < SMIN);
    cout = sub ? (ua >= ub) : ((ua + ub + int'(cin)) > UMAX);
    s = r[WIDTH-1:0];
`ifdef CHUNKED_ADDER_SAT_EN
    if (r > SMAX) s = WIDTH'(SMAX);
    else if (r < SMIN) s = WIDTH'(1 << (WIDTH - 1));
`endif
    return {ovf, cout, s};
  endfunction

  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub);
    int t = 0;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("accept_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(model(a, b, cin, sub));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
  endtask

  task automatic wait_result(output logic [WIDTH+1:0] exp);
    int lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'(NCHUNK));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("sum", 32'(bus.sum), 32'(exp[WIDTH-1:0]));
    check("cout", 32'(bus.cout), 32'(exp[WIDTH]));
    check("ovf", 32'(bus.ovf), 32'(exp[WIDTH+1]));
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_result(input logic [WIDTH+1:0] exp);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("after_hs_out_valid", 32'(bus.out_valid), 32'd0);
    check("after_hs_in_ready", 32'(bus.in_ready), 32'd1);
    check("after_hs_sum_held", 32'(bus.sum), 32'(exp[WIDTH-1:0]));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
    logic [WIDTH+1:0] exp;
    drive_op(a, b, cin, sub);
    wait_result(exp);
    release_result(exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH+1:0] exp, exp2;
    logic [WIDTH-1:0] ra, rb;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);

    // Directed corners
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    run_op(16'h0000, 16'h8000, 1'b0, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);

    // Backpressure: result must hold while new operands wait
    drive_op(16'hABCD, 16'h1357, 1'b1, 1'b0);
    wait_result(exp);
    bus.a = 16'h4444; bus.b = 16'h0123; bus.cin = 1'b0; bus.sub = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_sum_stable", 32'(bus.sum), 32'(exp[WIDTH-1:0]));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
    exp_q.push_back(model(16'h4444, 16'h0123, 1'b0, 1'b1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_accepted", 32'(bus.in_ready), 32'd0);
    wait_result(exp2);
    release_result(exp2);

    // Reset during RUN discards the operation
    drive_op(16'h2222, 16'h3333, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op(16'h2222, 16'h3333, 1'b1, 1'b0);

    // Random operations, with extreme operands mixed in
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'h7FFF;
        1: rb = 16'h8000;
        2: ra = 16'hFFFF;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/chunked_adder_seq.md
# chunked_adder_seq

Parametrised sequential ripple adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, starting from the least-significant chunk, and carries between chunks in a register. This lets wide additions run through a narrow adder slice. It sits between a valid/ready producer and consumer and also reports carry-out and signed overflow.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a−b, computed as a+~b+1, with cin ignored.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For sub=1, 1 means no borrow.
- ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Transitions:
  - IDLE→RUN on in_valid && in_ready. Capture a, b (or ~b when sub=1), and an initial carry of sub ? 1 : cin. Chunk counter k=0.
  - In RUN, each cycle adds chunk k of both captured operands plus the carry register, writes result bits [k*CHUNK +: CHUNK], updates the carry register, and increments k.
  - RUN→DONE after the chunk with k=NCHUNK−1. sum, cout and ovf become valid on entry to DONE.
  - DONE→IDLE on out_ready. Without out_ready, DONE holds indefinitely.
- Ordering and holding:
  - Only one operation is in flight; in_valid is ignored outside IDLE.
  - Captured operands are unaffected by later changes on a, b, cin and sub.
  - sum, cout and ovf are stable throughout DONE and hold their values after the handshake until the next entry to DONE.
- Arithmetic:
  - Modulo 2^WIDTH.
  - ovf is derived from the carry into bit WIDTH−1 and the final carry.
- Reset values:
  - state=IDLE, k=0, carry=0.
  - out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 from the first cycle after reset.
- Reset mid-operation, in RUN or DONE: the operation is discarded, out_valid never asserts for it, and the state returns to IDLE.
- Reset has priority over the input and output handshakes in the same cycle.

## Timing
- Operand accept edge = cycle 0. out_valid rises after edge NCHUNK, giving a latency of NCHUNK cycles.
- With out_ready held high, there is one operation every NCHUNK+2 cycles: NCHUNK in RUN, 1 in DONE, 1 in IDLE.
- When CHUNK=WIDTH, RUN lasts one cycle and latency is 1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro CHUNKED_ADDER_SAT_EN.
- Defined: when ovf=1, sum is saturated to the signed extreme.
  - Overflow past the positive limit gives 0 followed by all 1s, e.g. 0x7FFF.
  - Overflow past the negative limit gives 1 followed by all 0s, e.g. 0x8000.
  - ovf and cout still report the raw result.
  - Saturation is applied on entry to DONE, so latency is unchanged.
- Undefined: sum is always the wrapped modulo result, and no saturation logic is compiled in.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- a=0x1234, b=0x1111, cin=0, sub=0 → out_valid 4 cycles after accept; sum=0x2345, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 → carry ripples through all chunks; sum=0x0000, cout=1, ovf=0. With cin=1 instead → sum=0x0001, cout=1.
- a=0x7FFF, b=0x0001, sub=0 → ovf=1, cout=0. sum=0x8000 without CHUNKED_ADDER_SAT_EN and 0x7FFF with it. a=0x8000, b=0xFFFF → ovf=1, cout=1, sum=0x7FFF without the macro and 0x8000 with it.
- a=0x0005, b=0x0007, sub=1, cin=1 → sum=0xFFFE, cout=0, ovf=0 (cin ignored). a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → out_valid stays 1, sum is stable and in_ready=0. Raise out_ready → next cycle is IDLE; new operands are accepted the cycle after that.
- Assert rst for one cycle at cycle 2 of RUN → out_valid never asserts for that operation; in_ready=1 and sum=0 the cycle after reset deasserts; a subsequent operation produces the correct result.
